// File: rtl/decoder_share_arbiter_pkg.sv
// Shared types and helpers for the decoder share arbiter.
// State encoding, default select width and a one-hot to index helper.
package decoder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HOLD    = 2'b01,
        RELEASE = 2'b10
    } state_t;

    localparam int SEL_W_DEF = 3;

    // Index of the set bit in a one-hot vector of up to eight requesters.
    function automatic int unsigned oh2idx(input logic [7:0] oh);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                r = r | i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_share_arbiter_if.sv
// Requester-side bundle of the decoder share arbiter.
// master = requester side, slave = arbiter side.
interface decoder_share_arbiter_if
    import decoder_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int SEL_W = SEL_W_DEF
);
    localparam int IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*SEL_W-1:0] codes;
    logic [N_REQ-1:0]       gnt;
    logic [SEL_W-1:0]       dec_sel;
    logic                   dec_en;
    logic                   busy;
    logic                   done;
    logic [IDX_W-1:0]       done_id;

    modport master (
        output req, codes,
        input  gnt, dec_sel, dec_en, busy, done, done_id
    );

    modport slave (
        input  req, codes,
        output gnt, dec_sel, dec_en, busy, done, done_id
    );

endinterface

// File: rtl/decoder_share_arbiter_rr_pick.sv
// Wrap-around first-set scan starting at ptr.
// valid is high when any request is set; idx is the winner.
module rr_pick
    import decoder_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);
    logic [N_REQ-1:0] oh;
    logic             found;
    int               pos;

    // Scan ptr, ptr+1, ... modulo N_REQ and mark the first active requester.
    always_comb begin
        oh    = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = (int'(ptr) + k) % N_REQ;
            if (!found && req[IDX_W'(pos)]) begin
                found = 1'b1;
                oh[IDX_W'(pos)] = 1'b1;
            end
        end
    end

    assign valid = found;
    assign idx   = IDX_W'(oh2idx(8'(oh)));

endmodule

// File: rtl/decoder_share_arbiter.sv
// Round-robin sharing of one clocked 3-8 decoder among N_REQ requesters.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority (starvation possible).
module decoder_share_arbiter
    import decoder_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int SEL_W    = SEL_W_DEF,
    parameter int HOLD_CYC = 2
) (
    input logic                    CP,
    input logic                    CLR,
    decoder_share_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    if (HOLD_CYC < 1) begin : g_hold_chk
        $error("HOLD_CYC must be at least 1");
    end
    if (N_REQ < 2 || N_REQ > 8) begin : g_nreq_chk
        $error("N_REQ must be in 2..8");
    end

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] win, win_n;
    logic [SEL_W-1:0] sel, sel_n;
    logic [IDX_W-1:0] ptr;
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

`ifdef ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [IDX_W-1:0] ptr_n;

    // Move priority just past the winner when its transaction releases.
    always_comb begin
        ptr_n = ptr;
        if (state == RELEASE) begin
            ptr_n = (win == IDX_W'(N_REQ - 1)) ? '0 : win + IDX_W'(1);
        end
    end

    // Priority pointer register.
    always_ff @(posedge CP) begin
        if (CLR) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_n;
        end
    end
`endif

    // FSM state, hold counter, winner and latched select.
    always_ff @(posedge CP) begin
        if (CLR) begin
            state <= IDLE;
            cnt   <= '0;
            win   <= '0;
            sel   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            win   <= win_n;
            sel   <= sel_n;
        end
    end

    // Next-state: grant in IDLE, count down in HOLD, one RELEASE cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        win_n   = win;
        sel_n   = sel;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_n = HOLD;
                    win_n   = pick_idx;
                    sel_n   = bus.codes[pick_idx*SEL_W +: SEL_W];
                    cnt_n   = CNT_W'(HOLD_CYC - 1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_n = RELEASE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            RELEASE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        bus.gnt     = '0;
        bus.dec_en  = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.done_id = '0;
        bus.dec_sel = sel;
        if (state == HOLD) begin
            bus.gnt    = N_REQ'(1) << win;
            bus.dec_en = 1'b1;
            bus.busy   = 1'b1;
        end
        if (state == RELEASE) begin
            bus.busy    = 1'b1;
            bus.done    = 1'b1;
            bus.done_id = win;
        end
    end

endmodule
